// File: rtl/obstacle_engine.sv
// Multi-slot obstacle generator: LFSR-spaced spawning, per-frame scrolling and retirement,
// plus a registered pixel hit query for the renderer and collision logic.
module obstacle_engine #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned X_W        = 10,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned OBS_W      = 16,
    parameter int unsigned MIN_GAP    = 128,
    parameter int unsigned GAP_RAND_W = 6,
    parameter int unsigned TYPE_W     = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       frame_tick,
    input  logic [3:0]                 speed,
    input  logic                       clear,
    input  logic                       seed_load,
    input  logic [15:0]                seed_in,
    input  logic [X_W-1:0]             px_x,
    output logic                       hit,
    output logic [TYPE_W-1:0]          hit_type,
    output logic [NUM_SLOTS-1:0]       obs_valid,
    output logic [NUM_SLOTS*X_W-1:0]   obs_x,
    output logic                       passed
);
    localparam int unsigned G_W = X_W + 1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [15:0]          lfsr, lfsr_nxt, lfsr_step;
    logic [G_W-1:0]       gap_cnt, gap_nxt, next_gap, ngap_nxt, gap_sat;
    logic [G_W:0]         gap_sum;
    logic [NUM_SLOTS-1:0] valid, valid_nxt;
    logic [X_W-1:0]       x_q   [NUM_SLOTS];
    logic [X_W-1:0]       x_nxt [NUM_SLOTS];
    logic [TYPE_W-1:0]    type_q   [NUM_SLOTS];
    logic [TYPE_W-1:0]    type_nxt [NUM_SLOTS];
    logic                 passed_nxt, retired, found;
    logic                 hit_c;
    logic [TYPE_W-1:0]    hit_type_c;

    // Gap accumulator saturates rather than wrapping while spawns are deferred.
    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    assign gap_sum   = {1'b0, gap_cnt} + (G_W+1)'(speed);
    assign gap_sat   = gap_sum[G_W] ? {G_W{1'b1}} : gap_sum[G_W-1:0];

    always_comb begin
        lfsr_nxt   = seed_load ? ((seed_in == 16'h0000) ? SEED : seed_in) : lfsr_step;
        valid_nxt  = valid;
        x_nxt      = x_q;
        type_nxt   = type_q;
        gap_nxt    = gap_cnt;
        ngap_nxt   = next_gap;
        passed_nxt = 1'b0;
        retired    = 1'b0;
        found      = 1'b0;
        if (clear) begin
            valid_nxt = '0;
            gap_nxt   = '0;
            ngap_nxt  = G_W'(MIN_GAP);
        end else if (run && frame_tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid[i]) begin
                    if (x_q[i] < X_W'(speed)) begin
                        valid_nxt[i] = 1'b0;
                        retired      = 1'b1;
                    end else begin
                        x_nxt[i] = x_q[i] - X_W'(speed);
                    end
                end
            end
            passed_nxt = retired;
            // Free slots are judged on pre-tick valid bits.
            if ((gap_sat >= next_gap) && (~valid != '0)) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!valid[i] && !found) begin
                        found        = 1'b1;
                        valid_nxt[i] = 1'b1;
                        x_nxt[i]     = X_W'(SCREEN_W - 1);
                        type_nxt[i]  = lfsr[TYPE_W-1:0];
                    end
                end
                gap_nxt  = '0;
                ngap_nxt = G_W'(MIN_GAP) + G_W'(lfsr[GAP_RAND_W-1:0]);
            end else begin
                gap_nxt = gap_sat;
            end
        end
    end

    // Pixel query against pre-edge slot state; the lowest-index hit supplies the type.
    always_comb begin
        hit_c      = 1'b0;
        hit_type_c = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (valid[i] && (px_x >= x_q[i]) &&
                ({1'b0, px_x} <= ({1'b0, x_q[i]} + G_W'(OBS_W - 1)))) begin
                hit_c      = 1'b1;
                hit_type_c = type_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= SEED;
            gap_cnt  <= '0;
            next_gap <= G_W'(MIN_GAP);
            valid    <= '0;
            passed   <= 1'b0;
            hit      <= 1'b0;
            hit_type <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]    <= '0;
                type_q[i] <= '0;
            end
        end else begin
            lfsr     <= lfsr_nxt;
            gap_cnt  <= gap_nxt;
            next_gap <= ngap_nxt;
            valid    <= valid_nxt;
            passed   <= passed_nxt;
            hit      <= hit_c;
            hit_type <= hit_type_c;
            x_q      <= x_nxt;
            type_q   <= type_nxt;
        end
    end

    assign obs_valid = valid;
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_obs_x
        assign obs_x[g*X_W +: X_W] = x_q[g];
    end

endmodule
